// File: rtl/adsr_poly.sv
// Polyphonic time-multiplexed ADSR envelope generator: one voice updated per clock
// through a single shared multiplier, one sweep per sample tick.
module adsr_poly #(
  parameter int TOTAL_BITS      = 32,
  parameter int FRACTIONAL_BITS = 16,
  parameter int VOICES          = 8,
  localparam int VW             = $clog2(VOICES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [VOICES-1:0]     gate,
  input  logic                  retrigger,
  input  logic [TOTAL_BITS-1:0] coef_a,
  input  logic [TOTAL_BITS-1:0] coef_d,
  input  logic [TOTAL_BITS-1:0] coef_r,
  input  logic [TOTAL_BITS-1:0] base_a,
  input  logic [TOTAL_BITS-1:0] base_d,
  input  logic [TOTAL_BITS-1:0] base_r,
  input  logic [TOTAL_BITS-1:0] s,
  output logic                  out_valid,
  output logic [VW-1:0]         out_voice,
  output logic [TOTAL_BITS-1:0] out_level,
  output logic [VOICES-1:0]     active,
  output logic                  busy,
  output logic                  tick_missed
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE
  } voice_state_t;

  localparam logic signed [TOTAL_BITS-1:0] ONE =
    {{(TOTAL_BITS-FRACTIONAL_BITS-1){1'b0}}, 1'b1, {FRACTIONAL_BITS{1'b0}}};

  voice_state_t                  state_reg [VOICES];
  logic signed [TOTAL_BITS-1:0]  level_reg [VOICES];
  logic [VOICES-1:0]             gate_prev_reg;
  logic [VOICES-1:0]             gate_snap_reg;
  logic                          busy_reg;
  logic [VW-1:0]                 idx_reg;
  logic                          out_valid_reg;
  logic [VW-1:0]                 out_voice_reg;
  logic [TOTAL_BITS-1:0]         out_level_reg;
  logic                          tick_missed_reg;

  voice_state_t                  cur_state;
  logic signed [TOTAL_BITS-1:0]  cur_level;
  logic signed [TOTAL_BITS-1:0]  mul_coef;
  logic signed [TOTAL_BITS-1:0]  add_base;
  logic signed [TOTAL_BITS-1:0]  sustain_level;
  logic signed [2*TOTAL_BITS-1:0] ext_level;
  logic signed [2*TOTAL_BITS-1:0] ext_coef;
  logic signed [2*TOTAL_BITS-1:0] prod_full;
  logic signed [TOTAL_BITS-1:0]  step_n;
  logic                          snap_bit;
  logic                          prev_bit;
  voice_state_t                  state_next;
  logic signed [TOTAL_BITS-1:0]  level_next;

  // The single multiplier: operand selection follows the slot's current stage.
  always_comb begin
    cur_state     = state_reg[idx_reg];
    cur_level     = level_reg[idx_reg];
    sustain_level = $signed(s);
    snap_bit      = gate_snap_reg[idx_reg];
    prev_bit      = gate_prev_reg[idx_reg];
    mul_coef      = $signed(coef_r);
    add_base      = $signed(base_r);
    if (cur_state == ST_ATTACK) begin
      mul_coef = $signed(coef_a);
      add_base = $signed(base_a);
    end else if (cur_state == ST_DECAY) begin
      mul_coef = $signed(coef_d);
      add_base = $signed(base_d);
    end
    ext_level = {{TOTAL_BITS{cur_level[TOTAL_BITS-1]}}, cur_level};
    ext_coef  = {{TOTAL_BITS{mul_coef[TOTAL_BITS-1]}}, mul_coef};
    prod_full = ext_level * ext_coef;
    step_n    = add_base + TOTAL_BITS'(prod_full >>> FRACTIONAL_BITS);
  end

  always_comb begin
    state_next = cur_state;
    level_next = cur_level;
    if (snap_bit && !prev_bit) begin
      state_next = ST_ATTACK;
      if (retrigger) level_next = '0;
    end else if (!snap_bit && prev_bit) begin
      if (cur_state != ST_IDLE) state_next = ST_RELEASE;
    end else begin
      case (cur_state)
        ST_ATTACK: begin
          if (step_n >= ONE) begin
            level_next = ONE;
            state_next = ST_DECAY;
          end else begin
            level_next = step_n;
          end
        end
        ST_DECAY: begin
          if (step_n <= sustain_level) begin
            level_next = sustain_level;
            state_next = ST_SUSTAIN;
          end else begin
            level_next = step_n;
          end
        end
        ST_SUSTAIN: level_next = sustain_level;
        ST_RELEASE: begin
          if (step_n <= 0) begin
            level_next = '0;
            state_next = ST_IDLE;
          end else begin
            level_next = step_n;
          end
        end
        default: level_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        state_reg[i] <= ST_IDLE;
        level_reg[i] <= '0;
      end
      gate_prev_reg   <= '0;
      gate_snap_reg   <= '0;
      busy_reg        <= 1'b0;
      idx_reg         <= '0;
      out_valid_reg   <= 1'b0;
      out_voice_reg   <= '0;
      out_level_reg   <= '0;
      tick_missed_reg <= 1'b0;
    end else begin
      out_valid_reg   <= 1'b0;
      tick_missed_reg <= tick & busy_reg;
      if (busy_reg) begin
        state_reg[idx_reg]     <= state_next;
        level_reg[idx_reg]     <= level_next;
        gate_prev_reg[idx_reg] <= snap_bit;
        out_valid_reg          <= 1'b1;
        out_voice_reg          <= idx_reg;
        out_level_reg          <= level_next;
        if (idx_reg == VW'(VOICES-1)) begin
          busy_reg <= 1'b0;
        end else begin
          idx_reg <= idx_reg + VW'(1);
        end
      end else if (tick) begin
        busy_reg      <= 1'b1;
        idx_reg       <= '0;
        gate_snap_reg <= gate;
      end
    end
  end

  for (genvar gi = 0; gi < VOICES; gi++) begin : g_active
    assign active[gi] = (state_reg[gi] != ST_IDLE);
  end

  assign out_valid   = out_valid_reg;
  assign out_voice   = out_voice_reg;
  assign out_level   = out_level_reg;
  assign busy        = busy_reg;
  assign tick_missed = tick_missed_reg;

endmodule

// File: tb/tb_adsr_poly.sv
// Bench for adsr_poly: directed envelope scenarios plus randomized sweeps checked
// against a per-voice behavioural envelope model.
module tb_adsr_poly;
  localparam int V   = 8;
  localparam int W   = 32;
  localparam int F   = 16;
  localparam int ONE = 1 << F;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           tick = 1'b0;
  logic [V-1:0]   gate = '0;
  logic           retrigger = 1'b1;
  logic [W-1:0]   coef_a = '0, coef_d = '0, coef_r = '0;
  logic [W-1:0]   base_a = '0, base_d = '0, base_r = '0;
  logic [W-1:0]   s = '0;
  logic           out_valid;
  logic [2:0]     out_voice;
  logic [W-1:0]   out_level;
  logic [V-1:0]   active;
  logic           busy;
  logic           tick_missed;

  adsr_poly #(.TOTAL_BITS(W), .FRACTIONAL_BITS(F), .VOICES(V)) dut (
    .clock(clock), .reset(reset), .tick(tick), .gate(gate), .retrigger(retrigger),
    .coef_a(coef_a), .coef_d(coef_d), .coef_r(coef_r),
    .base_a(base_a), .base_d(base_d), .base_r(base_r), .s(s),
    .out_valid(out_valid), .out_voice(out_voice), .out_level(out_level),
    .active(active), .busy(busy), .tick_missed(tick_missed)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef enum {M_IDLE, M_ATTACK, M_DECAY, M_SUSTAIN, M_RELEASE} mstate_t;
  mstate_t     m_state [V];
  int          m_level [V];
  bit          m_gprev [V];
  logic [W-1:0] exp_level [V];

  int          cap_voice [32];
  logic [W-1:0] cap_level [32];
  int          cap_cycle [32];
  bit          cap_busy  [32];
  int          n_valid;

  function automatic int m_step(int lvl, int b, int c);
    longint p = longint'(lvl) * longint'(c);
    return b + int'(p >>> F);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < V; k++) begin
      m_state[k] = M_IDLE;
      m_level[k] = 0;
      m_gprev[k] = 0;
    end
  endtask

  // One full sweep of the envelope rules for every voice using the current inputs.
  task automatic model_sweep();
    int n;
    for (int k = 0; k < V; k++) begin
      if (gate[k] && !m_gprev[k]) begin
        m_state[k] = M_ATTACK;
        if (retrigger) m_level[k] = 0;
      end else if (!gate[k] && m_gprev[k]) begin
        if (m_state[k] != M_IDLE) m_state[k] = M_RELEASE;
      end else begin
        case (m_state[k])
          M_ATTACK: begin
            n = m_step(m_level[k], int'(base_a), int'(coef_a));
            if (n >= ONE) begin m_level[k] = ONE; m_state[k] = M_DECAY; end
            else m_level[k] = n;
          end
          M_DECAY: begin
            n = m_step(m_level[k], int'(base_d), int'(coef_d));
            if (n <= int'(s)) begin m_level[k] = int'(s); m_state[k] = M_SUSTAIN; end
            else m_level[k] = n;
          end
          M_SUSTAIN: m_level[k] = int'(s);
          M_RELEASE: begin
            n = m_step(m_level[k], int'(base_r), int'(coef_r));
            if (n <= 0) begin m_level[k] = 0; m_state[k] = M_IDLE; end
            else m_level[k] = n;
          end
          default: m_level[k] = 0;
        endcase
      end
      m_gprev[k] = gate[k];
      exp_level[k] = m_level[k];
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues a tick and records every output pulse within a bounded window.
  task automatic run_sweep();
    model_sweep();
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    n_valid = 0;
    for (int c = 1; c <= V + 3; c++) begin
      cap_busy[c] = busy;
      if (out_valid) begin
        if (n_valid < 32) begin
          cap_voice[n_valid] = int'(out_voice);
          cap_level[n_valid] = out_level;
          cap_cycle[n_valid] = c;
        end
        n_valid++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (active !== '0) begin errors++; $display("FAIL reset_active: got %h expected 0", active); end
    checks++; if (out_level !== '0 || out_voice !== '0) begin errors++; $display("FAIL reset_out_data: got voice %0d level %h expected 0/0", out_voice, out_level); end
    checks++; if (tick_missed !== 1'b0) begin errors++; $display("FAIL reset_tick_missed: got %b expected 0", tick_missed); end
  endtask

  task automatic test_idle_sweep();
    gate = '0;
    run_sweep();
    checks++; if (n_valid != V) begin errors++; $display("FAIL idle_count: got %0d expected %0d", n_valid, V); end
    for (int k = 0; k < V && k < n_valid; k++) begin
      checks++;
      if (cap_voice[k] != k || cap_cycle[k] != k + 2 || cap_level[k] !== '0) begin
        errors++;
        $display("FAIL idle_slot%0d: got voice %0d cycle %0d level %h expected voice %0d cycle %0d level 0",
                 k, cap_voice[k], cap_cycle[k], cap_level[k], k, k + 2);
      end
    end
    for (int c = 1; c <= V + 1; c++) begin
      checks++;
      if (cap_busy[c] !== (c <= V)) begin errors++; $display("FAIL idle_busy_c%0d: got %b expected %b", c, cap_busy[c], c <= V); end
    end
    checks++; if (active !== '0) begin errors++; $display("FAIL idle_active: got %h expected 0", active); end
  endtask

  task automatic test_attack_decay();
    logic [W-1:0] want [4];
    want[0] = 32'h0; want[1] = 32'h0A666; want[2] = 32'h0F999; want[3] = 32'h10000;
    coef_a = 32'h8000; base_a = 32'h0A666; s = 32'h8000;
    retrigger = 1'b1; gate = 8'h01;
    for (int i = 0; i < 4; i++) begin
      run_sweep();
      checks++;
      if (cap_level[0] !== want[i] || !active[0]) begin
        errors++;
        $display("FAIL attack_step%0d: got level %h active %b expected level %h active 1", i, cap_level[0], active[0], want[i]);
      end
    end
    coef_d = 32'h0; base_d = 32'h7FFF;
    run_sweep();
    checks++; if (cap_level[0] !== 32'h8000) begin errors++; $display("FAIL decay_to_sustain: got %h expected 00008000", cap_level[0]); end
  endtask

  task automatic test_sustain_release();
    s = 32'h4000;
    run_sweep();
    checks++; if (cap_level[0] !== 32'h4000) begin errors++; $display("FAIL sustain_track: got %h expected 00004000", cap_level[0]); end
    gate = '0;
    run_sweep();
    checks++; if (cap_level[0] !== 32'h4000 || !active[0]) begin errors++; $display("FAIL release_edge: got %h active %b expected 00004000 active 1", cap_level[0], active[0]); end
    coef_r = 32'h0; base_r = 32'hFFFFFFFF;
    run_sweep();
    checks++; if (cap_level[0] !== 32'h0 || active[0] !== 1'b0) begin errors++; $display("FAIL release_end: got %h active %b expected 0 active 0", cap_level[0], active[0]); end
  endtask

  task automatic test_legato_retrigger();
    coef_a = 32'h0; base_a = 32'h6000; retrigger = 1'b1;
    gate = 8'h01; run_sweep();
    gate = 8'h01; run_sweep();
    checks++; if (cap_level[0] !== 32'h6000) begin errors++; $display("FAIL legato_setup: got %h expected 00006000", cap_level[0]); end
    gate = 8'h00; run_sweep();
    retrigger = 1'b0; gate = 8'h01; run_sweep();
    checks++; if (cap_level[0] !== 32'h6000 || !active[0]) begin errors++; $display("FAIL legato_hold: got %h active %b expected 00006000 active 1", cap_level[0], active[0]); end
    gate = 8'h00; run_sweep();
    retrigger = 1'b1; gate = 8'h01; run_sweep();
    checks++; if (cap_level[0] !== 32'h0) begin errors++; $display("FAIL retrigger_zero: got %h expected 0", cap_level[0]); end
  endtask

  task automatic test_overrun();
    int nv = 0;
    int nm = 0;
    model_sweep();
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    for (int c = 1; c <= V + 6; c++) begin
      if (out_valid) nv++;
      if (tick_missed) nm++;
      tick = (c == 3);
      @(negedge clock);
    end
    tick = 1'b0;
    checks++; if (nv != V) begin errors++; $display("FAIL overrun_valid_count: got %0d expected %0d", nv, V); end
    checks++; if (nm != 1) begin errors++; $display("FAIL overrun_missed_count: got %0d expected 1", nm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midsweep();
    gate = '1; coef_a = 32'h4000; base_a = 32'h4000; retrigger = 1'b1;
    run_sweep();
    run_sweep();
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tick = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_voice !== '0 || out_level !== '0 || active !== '0 || busy !== 1'b0 || tick_missed !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset_outputs: got valid %b voice %0d level %h active %h busy %b missed %b expected all 0",
               out_valid, out_voice, out_level, active, busy, tick_missed);
    end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_tick_ignored: got busy %b expected 0", busy); end
    gate = '0;
    run_sweep();
    checks++; if (n_valid != V) begin errors++; $display("FAIL restart_count: got %0d expected %0d", n_valid, V); end
    for (int k = 0; k < V && k < n_valid; k++) begin
      checks++;
      if (cap_voice[k] != k || cap_level[k] !== '0) begin
        errors++;
        $display("FAIL restart_slot%0d: got voice %0d level %h expected voice %0d level 0", k, cap_voice[k], cap_level[k], k);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      gate      = V'($urandom);
      retrigger = 1'($urandom);
      coef_a    = $urandom_range(16'hFFFF);
      coef_d    = $urandom_range(16'hFFFF);
      coef_r    = $urandom_range(16'hFFFF);
      base_a    = $urandom_range(32'h12000, 32'h1000);
      base_d    = $urandom_range(32'h8000);
      base_r    = W'(int'($urandom_range(32'h2400)) - 32'h2000);
      s         = $urandom_range(ONE);
      run_sweep();
      checks++; if (n_valid != V) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, n_valid, V); end
      for (int k = 0; k < V && k < n_valid; k++) begin
        checks++;
        if (cap_voice[k] != k || cap_cycle[k] != k + 2 || cap_level[k] !== exp_level[k]) begin
          errors++;
          $display("FAIL rand%0d_slot%0d: got voice %0d cycle %0d level %h expected voice %0d cycle %0d level %h",
                   it, k, cap_voice[k], cap_cycle[k], cap_level[k], k, k + 2, exp_level[k]);
        end
      end
      for (int k = 0; k < V; k++) begin
        checks++;
        if (active[k] !== (m_state[k] != M_IDLE)) begin
          errors++;
          $display("FAIL rand%0d_active%0d: got %b expected %b", it, k, active[k], m_state[k] != M_IDLE);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_sweep();
    test_attack_decay();
    test_sustain_release();
    test_legato_retrigger();
    test_overrun();
    test_reset_midsweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
